// File: rtl/nsdp_checker_pkg.sv
// Shared types and widths for the NSDP checker run controller.
// Holds the run-state encoding, default bus widths and expected-field layout.
package nsdp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_HALTED  = 2'd2
  } run_state_e;

  localparam int ERR_W_DEF  = 18;
  localparam int DATA_W_DEF = 512;
  localparam int CNT_W_DEF  = 64;

  localparam int FDATA_W = 32;
  localparam int TADDR_W = 64;
  localparam int FC_W    = 32;
  localparam int SEQ_W   = 16;
  localparam int ECNT_W  = 32;

  typedef struct packed {
    logic [FDATA_W-1:0] fdata;
    logic [TADDR_W-1:0] taddr;
    logic [FC_W-1:0]    fc;
    logic [SEQ_W-1:0]   seq;
  } exp_fields_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    return (&v) ? v : v + ECNT_W'(1);
  endfunction

endpackage

// File: rtl/nsdp_activity_timer.sv
// Loadable down-counter; active is a registered "count is nonzero" flag that
// tracks the counter's next value so it rises on the same edge as the load.
module nsdp_activity_timer
  import nsdp_checker_pkg::*;
#(
  parameter int unsigned ACTIVE_TIMEOUT = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic active
);

  localparam int TMR_W = $clog2(ACTIVE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(ACTIVE_TIMEOUT);

  logic [TMR_W-1:0] count_q, count_d;
  logic             active_q, active_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - TMR_W'(1);
    end
    active_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/nsdp_result_ctl.sv
// Run controller for the NSDP packet checker: run/halt sequencing, result
// counters and a first-error snapshot, all presented as registered outputs.
module nsdp_result_ctl
  import nsdp_checker_pkg::*;
#(
  parameter int unsigned ACTIVE_TIMEOUT = 25000000,
  parameter int          ERR_W          = ERR_W_DEF,
  parameter int          DATA_W         = DATA_W_DEF,
  parameter int          CNT_W          = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_error,
  input  logic              res_valid,
  input  logic              res_malformed,
  input  logic [ERR_W-1:0]  res_error,
  input  logic [DATA_W-1:0] res_data,
  input  logic [31:0]       res_exp_fdata,
  input  logic [63:0]       res_exp_taddr,
  input  logic [31:0]       res_exp_fc,
  input  logic [15:0]       res_exp_seq,
  output logic              checker_enable,
  output logic              run_status,
  output logic              eth_active,
  output logic [ERR_W-1:0]  error,
  output logic [DATA_W-1:0] error_data,
  output logic [31:0]       expected_fdata,
  output logic [63:0]       expected_taddr,
  output logic [31:0]       expected_fc,
  output logic [15:0]       expected_seq,
  output logic [CNT_W-1:0]  packets_rcvd,
  output logic [CNT_W-1:0]  malformed_packets,
  output logic [31:0]       error_count
);

  run_state_e        state_q, state_d;
  logic              run_q, run_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;
  logic [CNT_W-1:0]  mal_q, mal_d;
  logic [ECNT_W-1:0] error_count_q, error_count_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  exp_fields_t       exp_q, exp_d;
  logic              has_err;

  assign has_err = (res_error != '0);

  // Commands are mutually exclusive by priority; a lower one only acts when
  // every higher one is absent or has no effect in the current state.
  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    mal_d         = mal_q;
    error_count_d = error_count_q;
    err_d         = err_q;
    data_d        = data_q;
    exp_d         = exp_q;

    if (start) begin
      state_d       = ST_RUNNING;
      pkt_d         = '0;
      mal_d         = '0;
      error_count_d = '0;
      err_d         = '0;
      data_d        = '0;
      exp_d         = '0;
    end else if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else if (clear_error && (state_q == ST_HALTED)) begin
      state_d = ST_RUNNING;
      err_d   = '0;
      data_d  = '0;
      exp_d   = '0;
    end else if (res_valid && (state_q != ST_IDLE)) begin
      pkt_d = pkt_q + CNT_W'(1);
      if (res_malformed) begin
        mal_d = mal_q + CNT_W'(1);
      end
      if (has_err) begin
        error_count_d = sat_inc(error_count_q);
        // Only the first error after start/clear is kept; HALTED freezes it.
        if (state_q == ST_RUNNING) begin
          state_d     = ST_HALTED;
          err_d       = res_error;
          data_d      = res_data;
          exp_d.fdata = res_exp_fdata;
          exp_d.taddr = res_exp_taddr;
          exp_d.fc    = res_exp_fc;
          exp_d.seq   = res_exp_seq;
        end
      end
    end

    run_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      run_q         <= 1'b0;
      pkt_q         <= '0;
      mal_q         <= '0;
      error_count_q <= '0;
      err_q         <= '0;
      data_q        <= '0;
      exp_q         <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      pkt_q         <= pkt_d;
      mal_q         <= mal_d;
      error_count_q <= error_count_d;
      err_q         <= err_d;
      data_q        <= data_d;
      exp_q         <= exp_d;
    end
  end

  // Activity is independent of run state: any result, even one discarded by
  // start, keeps the link marked active.
  nsdp_activity_timer #(
    .ACTIVE_TIMEOUT(ACTIVE_TIMEOUT)
  ) u_activity_timer (
    .clk   (clk),
    .reset (reset),
    .load  (res_valid),
    .active(eth_active)
  );

  assign checker_enable    = run_q;
  assign run_status        = run_q;
  assign error             = err_q;
  assign error_data        = data_q;
  assign expected_fdata    = exp_q.fdata;
  assign expected_taddr    = exp_q.taddr;
  assign expected_fc       = exp_q.fc;
  assign expected_seq      = exp_q.seq;
  assign packets_rcvd      = pkt_q;
  assign malformed_packets = mal_q;
  assign error_count       = error_count_q;

endmodule

// File: tb/tb_nsdp_result_ctl.sv
// Scoreboard bench for nsdp_result_ctl: a driver feeds a behavioural model and
// queues expectations; a monitor compares each registered response.
module tb_nsdp_result_ctl;

  localparam int T      = 8;
  localparam int ERR_W  = 18;
  localparam int DATA_W = 512;
  localparam int CNT_W  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0, stop = 1'b0, clear_error = 1'b0;
  logic              res_valid = 1'b0, res_malformed = 1'b0;
  logic [ERR_W-1:0]  res_error = '0;
  logic [DATA_W-1:0] res_data = '0;
  logic [31:0]       res_exp_fdata = '0;
  logic [63:0]       res_exp_taddr = '0;
  logic [31:0]       res_exp_fc = '0;
  logic [15:0]       res_exp_seq = '0;
  logic              checker_enable, run_status, eth_active;
  logic [ERR_W-1:0]  error;
  logic [DATA_W-1:0] error_data;
  logic [31:0]       expected_fdata;
  logic [63:0]       expected_taddr;
  logic [31:0]       expected_fc;
  logic [15:0]       expected_seq;
  logic [CNT_W-1:0]  packets_rcvd, malformed_packets;
  logic [31:0]       error_count;

  nsdp_result_ctl #(
    .ACTIVE_TIMEOUT(T), .ERR_W(ERR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .clear_error(clear_error), .res_valid(res_valid),
    .res_malformed(res_malformed), .res_error(res_error),
    .res_data(res_data), .res_exp_fdata(res_exp_fdata),
    .res_exp_taddr(res_exp_taddr), .res_exp_fc(res_exp_fc),
    .res_exp_seq(res_exp_seq), .checker_enable(checker_enable),
    .run_status(run_status), .eth_active(eth_active), .error(error),
    .error_data(error_data), .expected_fdata(expected_fdata),
    .expected_taddr(expected_taddr), .expected_fc(expected_fc),
    .expected_seq(expected_seq), .packets_rcvd(packets_rcvd),
    .malformed_packets(malformed_packets), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              run;
    bit              eth;
    bit [ERR_W-1:0]  err;
    bit [DATA_W-1:0] data;
    bit [31:0]       fd;
    bit [63:0]       ta;
    bit [31:0]       fc;
    bit [15:0]       sq;
    bit [63:0]       pk;
    bit [63:0]       mal;
    bit [31:0]       ec;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: a run mode, plain counters, a snapshot, and the
  // cycle index of the last result seen.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int      m_mode;
  exp_t    m;
  bit      m_has_res;
  longint  m_last, m_cyc;
  int      txn = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m = '{default: '0};
    m_has_res = 1'b0;
    m_last = 0;
    m_cyc = 0;
  endtask

  // Called at a negedge; applies one cycle of inputs and queues the response.
  task automatic drive(input bit st, input bit sp, input bit ce, input bit v,
                       input bit mf, input bit [ERR_W-1:0] e, input bit [15:0] sq);
    bit [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
    start = st; stop = sp; clear_error = ce; res_valid = v;
    res_malformed = mf; res_error = e; res_data = d;
    res_exp_fdata = $urandom(); res_exp_taddr = {$urandom(), $urandom()};
    res_exp_fc = $urandom(); res_exp_seq = sq;

    if (v) begin m_has_res = 1'b1; m_last = m_cyc; end
    if (st) begin
      m_mode = M_RUN;
      m.pk = 0; m.mal = 0; m.ec = 0; m.err = 0; m.data = 0;
      m.fd = 0; m.ta = 0; m.fc = 0; m.sq = 0;
    end else if (sp && m_mode != M_IDLE) begin
      m_mode = M_IDLE;
    end else if (ce && m_mode == M_HALT) begin
      m_mode = M_RUN;
      m.err = 0; m.data = 0; m.fd = 0; m.ta = 0; m.fc = 0; m.sq = 0;
    end else if (v && m_mode != M_IDLE) begin
      m.pk = m.pk + 1;
      if (mf) m.mal = m.mal + 1;
      if (e != 0) begin
        if (m.ec != 32'hFFFF_FFFF) m.ec = m.ec + 1;
        if (m_mode == M_RUN) begin
          m_mode = M_HALT;
          m.err = e; m.data = d; m.fd = res_exp_fdata; m.ta = res_exp_taddr;
          m.fc = res_exp_fc; m.sq = sq;
        end
      end
    end
    m.run = (m_mode == M_RUN);
    m.eth = m_has_res && ((m_cyc - m_last) < T);
    m_cyc++;
    exp_q.push_back(m);
    $display("txn %0d st=%0b sp=%0b ce=%0b v=%0b mf=%0b err=%05h -> mode=%0d pk=%0d mal=%0d ec=%0h eth=%0b",
             txn, st, sp, ce, v, mf, e, m_mode, m.pk, m.mal, m.ec, m.eth);
    txn++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0, 16'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".run_status"}, DATA_W'(run_status), '0);
    chk({tag, ".checker_enable"}, DATA_W'(checker_enable), '0);
    chk({tag, ".eth_active"}, DATA_W'(eth_active), '0);
    chk({tag, ".error"}, DATA_W'(error), '0);
    chk({tag, ".error_data"}, error_data, '0);
    chk({tag, ".expected"}, DATA_W'({expected_fdata, expected_taddr, expected_fc, expected_seq}), '0);
    chk({tag, ".packets_rcvd"}, DATA_W'(packets_rcvd), '0);
    chk({tag, ".malformed_packets"}, DATA_W'(malformed_packets), '0);
    chk({tag, ".error_count"}, DATA_W'(error_count), '0);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the async clear.
  task automatic reset_pulse(input string tag);
    start = 0; stop = 0; clear_error = 0; res_valid = 0; res_malformed = 0;
    res_error = '0;
    #2 reset = 1'b1;
    #1 chk_zero(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("run_status", DATA_W'(run_status), DATA_W'(e.run));
        chk("checker_enable", DATA_W'(checker_enable), DATA_W'(e.run));
        chk("eth_active", DATA_W'(eth_active), DATA_W'(e.eth));
        chk("error", DATA_W'(error), DATA_W'(e.err));
        chk("error_data", error_data, e.data);
        chk("expected_fdata", DATA_W'(expected_fdata), DATA_W'(e.fd));
        chk("expected_taddr", DATA_W'(expected_taddr), DATA_W'(e.ta));
        chk("expected_fc", DATA_W'(expected_fc), DATA_W'(e.fc));
        chk("expected_seq", DATA_W'(expected_seq), DATA_W'(e.sq));
        chk("packets_rcvd", DATA_W'(packets_rcvd), DATA_W'(e.pk));
        chk("malformed_packets", DATA_W'(malformed_packets), DATA_W'(e.mal));
        chk("error_count", DATA_W'(error_count), DATA_W'(e.ec));
      end
    end
  end

  initial begin : stimulus
    int r;
    bit st, sp, ce, v, mf;
    bit [ERR_W-1:0] e;
    model_reset();
    @(negedge clk);
    reset_pulse("por");

    // Good traffic, then first-error capture with a later error ignored.
    drive(1, 0, 0, 0, 0, '0, 16'h0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0, '0, 16'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, '0, 16'h0);
    drive(0, 0, 0, 1, 0, 18'h00004, 16'h1234);
    drive(0, 0, 0, 1, 0, 18'h00008, 16'h5555);
    drive(0, 0, 0, 1, 0, 18'h00008, 16'h6666);
    idle(2);
    drive(0, 0, 1, 0, 0, '0, 16'h0);
    idle(1);
    drive(0, 0, 0, 1, 1, 18'h00010, 16'hBEEF);
    drive(0, 1, 0, 0, 0, '0, 16'h0);
    drive(0, 0, 0, 1, 0, 18'h00020, 16'h0);

    // start together with an erroring result, then activity decay.
    drive(1, 0, 0, 1, 0, 18'h00001, 16'h0001);
    drive(0, 0, 0, 1, 0, '0, 16'h0);
    idle(T + 3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, '0, 16'h0);
    idle(2);

    // Randomised traffic with occasional commands.
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 99);
      st = (r < 3);
      sp = (r >= 3 && r < 6);
      ce = (r >= 6 && r < 14);
      v  = !sp && !ce && ($urandom_range(0, 2) != 0);
      mf = ($urandom_range(0, 4) == 0);
      e  = ($urandom_range(0, 3) == 0) ? ERR_W'($urandom_range(1, (1 << ERR_W) - 1)) : '0;
      drive(st, sp, ce, v, mf, e, 16'($urandom()));
    end

    // Saturation of error_count from a preloaded value.
    drive(1, 0, 0, 0, 0, '0, 16'h0);
    force dut.error_count_q = 32'hFFFF_FFFE;
    #1 release dut.error_count_q;
    m.ec = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 18'h00002, 16'h0);

    // Reset in the middle of traffic, then results in IDLE are not counted.
    reset_pulse("midrun");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 18'h00003, 16'h0);
    drive(1, 0, 0, 0, 0, '0, 16'h0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, '0, 16'h0);
    drive(0, 0, 0, 1, 0, 18'h00100, 16'h4321);
    idle(2);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
